// File: rtl/vga_pkg.sv
// Shared definitions for the VGA prefetch slice: FSM encoding, MIG command
// constant and default screen geometry.
package vga_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [2:0] MIG_INSTR_READ = 3'b001;

  localparam int unsigned DEF_SCREEN_W = 256;
  localparam int unsigned DEF_SCREEN_H = 192;

endpackage

// File: rtl/vga_block_ram.sv
// Line buffer storage: 32-bit word write port, 8-bit registered byte read port.
// Byte lane n of a word holds byte address {word, n} (little-endian).
module vga_block_ram #(
  parameter int unsigned DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-3:0] wr_addr,
  input  logic [31:0]              wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [7:0]               rd_data
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [31:0] mem [DEPTH/4];

  // Word write and registered byte-lane read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr[AW-1:2]][{rd_addr[1:0], 3'b000} +: 8];
  end

endmodule

// File: rtl/vga_line_prefetch.sv
// Frame-byte prefetcher: keeps a ring buffer of upcoming pixels filled with
// burst reads from a MIG user port, and serves them to the scan-out logic.
module vga_line_prefetch
  import vga_pkg::*;
#(
  parameter int unsigned SCREEN_W    = DEF_SCREEN_W,
  parameter int unsigned SCREEN_H    = DEF_SCREEN_H,
  parameter int unsigned BUF_BYTES   = 256,
  parameter int unsigned BURST_WORDS = 16,
  parameter logic [13:0] MEM_PREFIX  = 14'h0,
  localparam int unsigned AW = $clog2(BUF_BYTES),
  localparam int unsigned FW = $clog2(SCREEN_W * SCREEN_H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] rd_addr,
  input  logic          pop,
  input  logic          flush,
  input  logic [FW-1:0] flush_addr,
  output logic [7:0]    rgb,
  output logic          empty,
  output logic          underflow,
  output logic          mem_err,
  output logic          mem_cmd_en,
  output logic [2:0]    mem_cmd_instr,
  output logic [5:0]    mem_cmd_bl,
  output logic [29:0]   mem_cmd_byte_addr,
  input  logic          mem_cmd_full,
  output logic          mem_rd_en,
  input  logic [31:0]   mem_rd_data,
  input  logic          mem_rd_empty,
  input  logic          mem_rd_error
);

  localparam int unsigned FRAME = SCREEN_W * SCREEN_H;
  localparam int unsigned CW    = $clog2(BURST_WORDS + 1);
  localparam int unsigned LW    = 30 - 14;

  localparam logic [FW-1:0] HEAD_LAST   = FW'(FRAME - 1);
  localparam logic [FW-1:0] TAIL_LAST   = FW'(FRAME - 4);
  localparam logic [AW:0]   BUF_FULL    = (AW+1)'(BUF_BYTES);
  localparam logic [AW:0]   BURST_BYTES = (AW+1)'(4 * BURST_WORDS);
  localparam logic [CW-1:0] LAST_IDX    = CW'(BURST_WORDS - 1);

  logic [1:0]    rst_sync;
  logic          rst_i;
  state_t        state;
  logic [FW-1:0] head;
  logic [FW-1:0] tail;
  logic [AW:0]   valid_len;
  logic [CW-1:0] word_cnt;

  logic          word_acc;
  logic          last_word;
  logic          ram_we;
  logic          pop_ok;
  logic          space_ok;
  logic [FW-1:0] head_next;
  logic [FW-1:0] tail_next;
  logic [FW-1:0] flush_base;
  logic          unused_flush_lsb;

  // Reset asserts asynchronously but releases on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync <= '0;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_i = rst_sync[1];

  assign empty             = (valid_len == '0);
  assign mem_cmd_instr     = MIG_INSTR_READ;
  assign mem_cmd_bl        = 6'(BURST_WORDS - 1);
  assign mem_cmd_byte_addr = {MEM_PREFIX, LW'(tail)};

  // The command strobe and read strobe follow the port flags within the
  // cycle so a single-cycle pulse lands exactly when the port can take it.
  assign mem_cmd_en = (state == CMD) && !mem_cmd_full;
  assign mem_rd_en  = ((state == READ) || (state == DRAIN)) && !mem_rd_empty;

  assign word_acc   = mem_rd_en;
  assign last_word  = word_acc && (word_cnt == LAST_IDX);
  assign ram_we     = (state == READ) && word_acc && !flush;
  assign pop_ok     = pop && !empty && !flush;
  assign space_ok   = (BUF_FULL - valid_len) >= BURST_BYTES;
  assign head_next  = (head == HEAD_LAST) ? '0 : head + 1'b1;
  assign tail_next  = (tail == TAIL_LAST) ? '0 : tail + FW'(4);
  assign flush_base = {flush_addr[FW-1:2], 2'b00};

  assign unused_flush_lsb = ^flush_addr[1:0];

  // Buffer bookkeeping: head/tail pointers, fill level and sticky flags.
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      head      <= '0;
      tail      <= '0;
      valid_len <= '0;
      underflow <= 1'b0;
      mem_err   <= 1'b0;
    end else begin
      if (flush) begin
        head      <= flush_base;
        tail      <= flush_base;
        valid_len <= '0;
        underflow <= 1'b0;
      end else begin
        if (pop_ok) begin
          head <= head_next;
        end
        if (ram_we) begin
          tail <= tail_next;
        end
        case ({ram_we, pop_ok})
          2'b10:   valid_len <= valid_len + (AW+1)'(4);
          2'b01:   valid_len <= valid_len - 1'b1;
          2'b11:   valid_len <= valid_len + (AW+1)'(3);
          default: valid_len <= valid_len;
        endcase
        if (pop && empty) begin
          underflow <= 1'b1;
        end
      end
      // An error seen in the same cycle as a flush is kept rather than lost.
      if (mem_rd_error) begin
        mem_err <= 1'b1;
      end else if (flush) begin
        mem_err <= 1'b0;
      end
    end
  end

  // Burst sequencer. A flush after the command was accepted must still
  // swallow the outstanding burst, so it diverts to DRAIN instead of IDLE.
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      word_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (space_ok) begin
            state <= CMD;
          end
        end
        CMD: begin
          word_cnt <= '0;
          if (flush) begin
            state <= mem_cmd_en ? DRAIN : IDLE;
          end else if (mem_cmd_en) begin
            state <= READ;
          end
        end
        READ: begin
          if (last_word) begin
            word_cnt <= '0;
            state    <= IDLE;
          end else begin
            if (word_acc) begin
              word_cnt <= word_cnt + 1'b1;
            end
            if (flush) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (last_word) begin
            word_cnt <= '0;
            state    <= IDLE;
          end else if (word_acc) begin
            word_cnt <= word_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  vga_block_ram #(
    .DEPTH(BUF_BYTES)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_we),
    .wr_addr (tail[AW-1:2]),
    .wr_data (mem_rd_data),
    .rd_addr (rd_addr),
    .rd_data (rgb)
  );

endmodule

// File: doc/vga_line_prefetch.md
VGA_LINE_PREFETCH -- requirements
Module: vga_line_prefetch

Interface
REQ-001 SHALL have parameter SCREEN_W, default 256, pixels per line.
REQ-002 SHALL have parameter SCREEN_H, default 192, lines per frame.
REQ-003 SHALL have parameter BUF_BYTES, default 256, buffer depth in bytes; power of 2, divides SCREEN_W, at least 8*BURST_WORDS.
REQ-004 SHALL have parameter BURST_WORDS, default 16, 32-bit words per memory read; 4*BURST_WORDS divides SCREEN_W*SCREEN_H.
REQ-005 SHALL have parameter MEM_PREFIX, default 14'h0, upper byte-address bits of the graphics region.
REQ-006 SHALL list clk input 1: sole clock, rising edge.
REQ-007 SHALL list rst_n input 1: asynchronous active-low reset.
REQ-008 SHALL list rd_addr input AW=log2(BUF_BYTES): pixel index (x mod BUF_BYTES).
REQ-009 SHALL list pop input 1: consume the oldest valid byte.
REQ-010 SHALL list flush input 1: discard contents and re-seek.
REQ-011 SHALL list flush_addr input FW=log2(SCREEN_W*SCREEN_H): new frame byte address.
REQ-012 SHALL list rgb output 8: pixel data. empty output 1: valid_len==0. underflow output 1: sticky, pop while empty. mem_err output 1: sticky, mem_rd_error seen.
REQ-013 SHALL list mem_cmd_en output 1, mem_cmd_instr output 3, mem_cmd_bl output 6, mem_cmd_byte_addr output 30, mem_cmd_full input 1.
REQ-014 SHALL list mem_rd_en output 1, mem_rd_data input 32, mem_rd_empty input 1, mem_rd_error input 1.

Function
REQ-015 SHALL return rgb one cycle after rd_addr (registered block-RAM read), independent of validity.
REQ-016 SHALL track head (oldest valid frame address), tail (next unfetched address, 4-byte aligned) and valid_len (0..BUF_BYTES).
REQ-017 SHALL, on pop with !empty and no flush, advance head by 1, wrapping SCREEN_W*SCREEN_H-1 to 0; pop while empty ignored and sets underflow.
REQ-018 SHALL hold mem_cmd_instr=3'b001 and mem_cmd_bl=BURST_WORDS-1 constant; mem_cmd_byte_addr={MEM_PREFIX, tail zero-extended}.
REQ-019 SHALL use states IDLE, CMD, READ, DRAIN.
REQ-020 IDLE->CMD when BUF_BYTES-valid_len >= 4*BURST_WORDS.
REQ-021 CMD: pulse mem_cmd_en one cycle in the first cycle mem_cmd_full is low, then ->READ with word counter cleared.
REQ-022 READ: assert mem_rd_en whenever !mem_rd_empty; each accepted word written at buffer word tail[AW-1:2] the same edge, tail+=4 (frame wrap), valid_len+=4; after BURST_WORDS words ->IDLE.
REQ-023 SHALL apply simultaneous word write and pop as valid_len+3 net.
REQ-024 flush SHALL set head=tail={flush_addr[FW-1:2],2'b00}, valid_len=0, clear underflow and mem_err, take priority over pop in that cycle.
REQ-025 flush in CMD SHALL abandon the command (->IDLE) if mem_cmd_en not yet pulsed, else ->DRAIN; flush in READ ->DRAIN.
REQ-026 DRAIN: accept and discard remaining words of the outstanding burst (no RAM write, no tail/valid_len change), then ->IDLE; a further flush in DRAIN updates addresses only.
REQ-027 mem_rd_error SHALL set mem_err; behaviour otherwise unchanged.
REQ-028 SHALL never issue a second command while a burst is outstanding.

Reset
REQ-029 rst_n low SHALL asynchronously force state IDLE, head=tail=0, valid_len=0, counters 0, mem_cmd_en=0, mem_rd_en=0, underflow=0, mem_err=0; empty=1; rgb undefined until first write.
REQ-030 Release SHALL be synchronised; first command issues within 3 cycles of release.

Structure
REQ-031 Shared package vga_pkg SHALL hold state encoding, MIG read-instruction constant and default screen dimensions.
REQ-032 Buffer storage SHALL be one sub-module, vga_block_ram, parametrised by depth (32-bit write port, 8-bit registered read port).

Verification
REQ-033 Reset release, mem model always ready -> cmd at addr 0, then 64, 128, 192; valid_len reaches 256, no further cmd.
REQ-034 Pop 256 bytes at one per cycle from full with 4-cycle memory latency -> empty never asserts, underflow stays 0.
REQ-035 Fill to tail=49088, pop continuously -> next cmd addresses 49088 then 0; rgb at rd_addr 0 returns frame byte 0.
REQ-036 Flush flush_addr=1027 mid-READ after 5 of 16 words -> 11 words discarded, next cmd addr 1024, empty=1 until first word.
REQ-037 Pop with valid_len=0 -> underflow=1, head unchanged; next flush clears it.
REQ-038 mem_cmd_full held high 20 cycles in CMD -> single mem_cmd_en pulse after release; mem_rd_error pulse -> mem_err=1 sticky.
